// File: rtl/uart_tx_fifo_feeder.sv
// Host-side byte FIFO feeding the UART TX controller one frame at a time.
// Launches a one-cycle strobe per word and paces itself off tx_busy.
//
// state     | meaning
// ----------+--------------------------------------------------------
// IDLE      | waiting for a queued word; pops and launches when !empty
// LAUNCH    | tx_data_valid high for this single cycle
// WAIT_BUSY | waiting for tx_busy to rise; timer expiry flags tx_err
// WAIT_DONE | frame in flight; returns to IDLE when tx_busy falls
module uart_tx_fifo_feeder #(
    parameter int DATA_WIDTH   = 8,
    parameter int DEPTH        = 8,
    parameter int ADDR_WIDTH   = 3,
    parameter int BUSY_TIMEOUT = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  full,
    output logic                  empty,
    output logic [ADDR_WIDTH:0]   fifo_count,
    output logic                  overflow,
    output logic                  tx_err,
    input  logic                  err_clr,
    input  logic                  tx_busy,
    output logic                  tx_data_valid,
    output logic [DATA_WIDTH-1:0] tx_data
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LAUNCH    = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

    localparam int                  TMR_W    = $clog2(BUSY_TIMEOUT);
    localparam logic [TMR_W-1:0]    TMR_LOAD = TMR_W'(BUSY_TIMEOUT - 1);
    localparam logic [ADDR_WIDTH:0] CNT_FULL = (ADDR_WIDTH + 1)'(DEPTH);

    state_t                  state;
    state_t                  state_next;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];
    logic [ADDR_WIDTH-1:0]   wr_ptr;
    logic [ADDR_WIDTH-1:0]   rd_ptr;
    logic [TMR_W-1:0]        tmr;
    logic                    wr_acc;
    logic                    wr_drop;
    logic                    pop;
    logic                    tmr_load;
    logic                    timeout_hit;

    assign full    = (fifo_count == CNT_FULL);
    assign empty   = (fifo_count == '0);
    assign wr_acc  = wr_en & ~full;
    assign wr_drop = wr_en & full;

    // Storage carries no reset; only the pointers and count define content.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
            end
            case ({wr_acc, pop})
                2'b10:   fifo_count <= fifo_count + (ADDR_WIDTH + 1)'(1);
                2'b01:   fifo_count <= fifo_count - (ADDR_WIDTH + 1)'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_data <= '0;
        end else if (pop) begin
            tx_data <= mem[rd_ptr];
        end
    end

    // Busy-rise timer counts down from BUSY_TIMEOUT-1; zero is terminal.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tmr <= '0;
        end else if (tmr_load) begin
            tmr <= TMR_LOAD;
        end else if (state == WAIT_BUSY && tmr != '0) begin
            tmr <= tmr - TMR_W'(1);
        end
    end

    // A new error in the same cycle as err_clr keeps the sticky bit set.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overflow <= 1'b0;
            tx_err   <= 1'b0;
        end else begin
            overflow <= wr_drop     | (overflow & ~err_clr);
            tx_err   <= timeout_hit | (tx_err   & ~err_clr);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (!empty) begin
                    state_next = LAUNCH;
                end
            end
            LAUNCH: begin
                state_next = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (tx_busy) begin
                    state_next = WAIT_DONE;
                end else if (tmr == '0) begin
                    state_next = IDLE;
                end
            end
            WAIT_DONE: begin
                if (!tx_busy) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Strobe decoded from registered state so reset drops it at once.
    always_comb begin
        pop           = 1'b0;
        tx_data_valid = 1'b0;
        tmr_load      = 1'b0;
        timeout_hit   = 1'b0;
        case (state)
            IDLE:      pop = ~empty;
            LAUNCH: begin
                tx_data_valid = 1'b1;
                tmr_load      = 1'b1;
            end
            WAIT_BUSY: timeout_hit = ~tx_busy & (tmr == '0);
            default: ;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_fifo_feeder.sv
// Scoreboard bench for uart_tx_fifo_feeder with a small TX-controller busy model.
module tb_uart_tx_fifo_feeder;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       full;
    logic       empty;
    logic [3:0] fifo_count;
    logic       overflow;
    logic       tx_err;
    logic       err_clr = 1'b0;
    logic       tx_busy = 1'b0;
    logic       tx_data_valid;
    logic [7:0] tx_data;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_q[$];
    logic [7:0] mon_exp;
    int         cyc = 0;
    int         strobes = 0;
    int         prev_cyc = 0;
    bit         have_prev = 1'b0;
    bit         chk_spacing = 1'b0;
    int         busy_mode = 0;   // 0 frame model, 1 hold busy, 2 never busy
    int         frame_len = 10;
    int         busy_cnt = 0;
    int         s_before;

    uart_tx_fifo_feeder #(
        .DATA_WIDTH(8), .DEPTH(8), .ADDR_WIDTH(3), .BUSY_TIMEOUT(4)
    ) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data),
        .full(full), .empty(empty), .fifo_count(fifo_count),
        .overflow(overflow), .tx_err(tx_err), .err_clr(err_clr),
        .tx_busy(tx_busy), .tx_data_valid(tx_data_valid), .tx_data(tx_data)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Controller model: busy rises on the strobe and stays up frame_len cycles.
    always @(negedge clk) begin
        if (!rst) begin
            tx_busy  = 1'b0;
            busy_cnt = 0;
        end else begin
            case (busy_mode)
                0: begin
                    if (tx_data_valid) begin
                        tx_busy  = 1'b1;
                        busy_cnt = frame_len;
                    end else if (busy_cnt > 1) begin
                        busy_cnt--;
                    end else begin
                        busy_cnt = 0;
                        tx_busy  = 1'b0;
                    end
                end
                1: if (tx_data_valid) tx_busy = 1'b1;
                default: tx_busy = 1'b0;
            endcase
        end
    end

    // Monitor: every strobe must match the next queued word, in order.
    always @(negedge clk) begin
        if (rst && tx_data_valid) begin
            strobes++;
            if (chk_spacing && have_prev)
                chk("strobe_spacing", 32'(cyc - prev_cyc), 32'(frame_len + 2));
            have_prev = 1'b1;
            prev_cyc  = cyc;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_strobe actual=%02h required=no_strobe (t=%0t)", tx_data, $time);
            end else begin
                mon_exp = exp_q.pop_front();
                chk("tx_data_order", 32'(tx_data), 32'(mon_exp));
            end
        end
    end

    // Called at a negedge; the word is sampled at the following posedge.
    task automatic write_word(input logic [7:0] d, input bit push);
        wr_en   = 1'b1;
        wr_data = d;
        if (push) exp_q.push_back(d);
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic wait_strobe(input string name);
        int n = 0;
        while (!tx_data_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk(name, 32'(tx_data_valid), 32'd1);
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || tx_busy || !empty) && n < 300) begin
            @(negedge clk);
            n++;
        end
        repeat (4) @(negedge clk);
        chk(name, 32'(n < 300), 32'd1);
    endtask

    task automatic set_mode_safe(input int m);
        @(posedge clk);
        #2;
        busy_mode = m;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_count", 32'(fifo_count), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_valid", 32'(tx_data_valid), 32'd0);
        chk("rst_data", 32'(tx_data), 32'h00);
        chk("rst_flags", 32'({overflow, tx_err}), 32'd0);
        rst = 1'b1;

        // Single word: accepted at E0, strobe during E1..E2 only
        @(negedge clk);
        write_word(8'hA5, 1'b1);
        chk("sw_count_after_e0", 32'(fifo_count), 32'd1);
        chk("sw_valid_after_e0", 32'(tx_data_valid), 32'd0);
        @(negedge clk);
        chk("sw_valid_after_e1", 32'(tx_data_valid), 32'd1);
        chk("sw_empty_after_e1", 32'(empty), 32'd1);
        @(negedge clk);
        chk("sw_valid_one_cycle", 32'(tx_data_valid), 32'd0);
        chk("sw_data_held", 32'(tx_data), 32'hA5);
        repeat (14) @(negedge clk);
        chk("sw_no_extra_strobe", 32'(strobes), 32'd1);

        // Busy timeout: four WAIT_BUSY cycles, then tx_err; word not retried
        busy_mode = 2;
        @(negedge clk);
        write_word(8'h3C, 1'b1);
        wait_strobe("to_strobe");
        repeat (4) @(negedge clk);
        chk("to_err_not_yet", 32'(tx_err), 32'd0);
        @(negedge clk);
        chk("to_err_set", 32'(tx_err), 32'd1);
        chk("to_empty", 32'(empty), 32'd1);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        chk("to_err_cleared", 32'(tx_err), 32'd0);
        repeat (6) @(negedge clk);
        chk("to_no_retry", 32'(strobes), 32'd2);

        // Burst fill while a frame is held busy, overflow on the 9th write
        busy_mode = 1;
        write_word(8'h0F, 1'b1);
        wait_strobe("bf_primer_strobe");
        repeat (3) @(negedge clk);
        for (int i = 0; i < 8; i++) write_word(8'h10 + 8'(i), 1'b1);
        chk("bf_full", 32'(full), 32'd1);
        chk("bf_count8", 32'(fifo_count), 32'd8);
        chk("bf_no_ovf_yet", 32'(overflow), 32'd0);
        err_clr = 1'b1;
        write_word(8'h99, 1'b0);
        err_clr = 1'b0;
        chk("bf_ovf_beats_clr", 32'(overflow), 32'd1);
        chk("bf_count_stays8", 32'(fifo_count), 32'd8);
        frame_len   = 6;
        have_prev   = 1'b0;
        chk_spacing = 1'b1;
        set_mode_safe(0);
        drain("bf_drain");
        chk_spacing = 1'b0;
        chk("bf_drained_count", 32'(fifo_count), 32'd0);
        chk("bf_drained_empty", 32'(empty), 32'd1);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        chk("bf_ovf_cleared", 32'(overflow), 32'd0);

        // Write on the IDLE->LAUNCH edge leaves the count unchanged
        busy_mode = 1;
        write_word(8'h20, 1'b1);
        wait_strobe("sim_primer_strobe");
        repeat (3) @(negedge clk);
        write_word(8'h21, 1'b1);
        write_word(8'h22, 1'b1);
        write_word(8'h23, 1'b1);
        chk("sim_count3", 32'(fifo_count), 32'd3);
        frame_len = 4;
        set_mode_safe(0);
        @(negedge clk);            // busy drops here
        @(negedge clk);            // FSM now in IDLE
        write_word(8'h24, 1'b1);   // sampled on the pop edge
        chk("sim_count_same", 32'(fifo_count), 32'd3);
        chk("sim_launched", 32'(tx_data_valid), 32'd1);
        drain("sim_drain");

        // Wrap-around: 12 writes interleaved with launches
        frame_len = 3;
        for (int i = 0; i < 12; i++) begin
            write_word(8'h40 + 8'(i), 1'b1);
            @(negedge clk);
        end
        chk("wr_no_overflow", 32'(overflow), 32'd0);
        drain("wr_drain");
        chk("wr_empty", 32'(empty), 32'd1);
        chk("wr_not_full", 32'(full), 32'd0);
        chk("wr_count0", 32'(fifo_count), 32'd0);

        // Reset in WAIT_DONE with two words queued
        busy_mode = 1;
        write_word(8'h50, 1'b1);
        wait_strobe("rm_strobe");
        repeat (3) @(negedge clk);
        write_word(8'h51, 1'b0);
        write_word(8'h52, 1'b0);
        chk("rm_count2", 32'(fifo_count), 32'd2);
        rst = 1'b0;
        #1;
        chk("rm_count0", 32'(fifo_count), 32'd0);
        chk("rm_empty", 32'(empty), 32'd1);
        chk("rm_valid0", 32'(tx_data_valid), 32'd0);
        chk("rm_data0", 32'(tx_data), 32'h00);
        chk("rm_flags0", 32'({overflow, tx_err, full}), 32'd0);
        busy_mode = 0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        s_before = strobes;
        repeat (20) @(negedge clk);
        chk("rm_no_strobe", 32'(strobes), 32'(s_before));
        write_word(8'h5A, 1'b1);
        wait_strobe("rm_new_strobe");
        drain("rm_drain");
        chk("sb_all_sent", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo_feeder.md
Name: uart_tx_fifo_feeder

Overview:
Buffers parallel bytes from the host side and feeds the UART transmit controller one frame at a time. Sits directly upstream of the TX FSM/serializer. It drives the one-cycle data_valid strobe and the parallel data word. It paces itself off the controller's busy output so frames go out back-to-back without loss.

Parameters:
DATA_WIDTH, 8, width of each queued word and of tx_data
DEPTH, 8, FIFO entries; power of two, at least 2
ADDR_WIDTH, 3, log2(DEPTH); pointer width
BUSY_TIMEOUT, 4, cycles to wait for tx_busy to rise after a launch before declaring an error; at least 2

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-low reset
wr_en  input  1  write request from host
wr_data  input  DATA_WIDTH  word to enqueue
full  output  1  FIFO holds DEPTH words
empty  output  1  FIFO holds 0 words
fifo_count  output  ADDR_WIDTH+1  current occupancy, 0..DEPTH
overflow  output  1  sticky; set when a write is dropped
tx_err  output  1  sticky; set on busy timeout
err_clr  input  1  synchronous clear of overflow and tx_err
tx_busy  input  1  busy from the UART TX controller
tx_data_valid  output  1  one-cycle launch strobe to the TX controller
tx_data  output  DATA_WIDTH  parallel word to the serializer; held stable until the next launch

Behaviour:
- Clock and reset: one clock (clk). rst is asynchronous, active-low.
- Reset state: state=IDLE, rd_ptr=wr_ptr=0, fifo_count=0, empty=1, full=0, overflow=0, tx_err=0, tx_data_valid=0, tx_data=0. Memory contents are don't-care.
- Write accept: wr_acc = wr_en & ~full, where full is the registered value for the current cycle. Accepted word goes to mem[wr_ptr]; wr_ptr increments modulo DEPTH.
- Dropped write: wr_en & full drops the word and sets overflow. This applies even if a pop happens in the same cycle.
- Pop: pop=1 only in the IDLE→LAUNCH transition.
- Occupancy: fifo_count_next = fifo_count + wr_acc - pop. full = (fifo_count==DEPTH). empty = (fifo_count==0). All three are registered or derived from registered count.
- Simultaneous events:
  - Write and pop in the same cycle: count unchanged, both pointers advance.
  - err_clr and a new error in the same cycle: the error wins (sticky bit stays 1).
- State machine (2-bit):
  - IDLE: if ~empty, then tx_data <= mem[rd_ptr], rd_ptr++, tx_data_valid <= 1, go to LAUNCH. Otherwise stay.
  - LAUNCH: tx_data_valid high for exactly this one cycle. Next: tx_data_valid <= 0, timeout counter <= 0, go to WAIT_BUSY.
  - WAIT_BUSY: if tx_busy=1, go to WAIT_DONE. Otherwise increment the counter. When the counter reaches BUSY_TIMEOUT-1 with tx_busy still 0: set tx_err, go to IDLE. The word is treated as consumed and is not retried.
  - WAIT_DONE: when tx_busy=0 (controller in stop or idle), go to IDLE.
- Latency:
  - Write accepted at edge E0 into an empty FIFO in IDLE: launch at E1; tx_data_valid high E1..E2.
  - The controller asserts busy in the cycle after the strobe.
- Frame spacing: minimum strobe-to-strobe spacing is frame length + 2 cycles. The falling busy edge is followed by IDLE then LAUNCH, which guarantees the controller is back in idle/stop when the strobe arrives.
- tx_data changes only on the IDLE→LAUNCH edge.
- Reset mid-operation: everything returns to reset values immediately. Queued words and the in-flight word are discarded. tx_data_valid drops asynchronously.
- Pointer wrap: pointers roll DEPTH-1→0 with no gap. ADDR_WIDTH+1 count distinguishes full from empty.

Test Plan:
- Single word: reset, write 0xA5, model controller asserts busy 1 cycle after the strobe for 10 cycles → tx_data_valid high exactly 1 cycle at E1, tx_data=0xA5, empty=1 after E1, back to IDLE after busy falls.
- Burst fill: write 8 words 0x10..0x17 back-to-back while tx_busy held 1 → full=1, fifo_count=8. A 9th write sets overflow=1, count stays 8. Release busy model → bytes leave in order 0x10..0x17; each strobe follows the previous busy fall by 2 cycles.
- Wrap-around: 12 writes interleaved with launches (depth 8) → output order matches input order, and full/empty are correct across pointer wrap.
- Simultaneous write and pop: FIFO holds 3, write occurs on the IDLE→LAUNCH edge → fifo_count stays 3.
- Timeout: tx_busy tied 0, write 0x3C → one strobe, tx_err=1 after 4 WAIT_BUSY cycles, FIFO empty. err_clr pulse → tx_err=0.
- Reset mid-frame: assert rst while in WAIT_DONE with 2 words queued → all outputs at reset values within the reset cycle. No strobe after release until a new write.
